// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch unit.
// Issues word-aligned fetch requests on a grant/rvalid memory port, buffers
// in-order responses in a DEPTH-entry FIFO and hands them to the decoder on
// a valid/ready interface. A redirect flushes the buffer; responses still in
// flight from the old stream are drained and discarded before fetching the
// new target. Credits (fifo_count + outstanding < DEPTH) guarantee the FIFO
// never overflows.
// Optional feature: define IFU_PERF_CNT_EN to add the performance counters
// perf_fetched_o (handshakes) and perf_stall_o (cycles without valid).

// Simulation-only checker: a response must never arrive while the FIFO is full.
module ifu_prefetch_chk (
  input logic clock,
  input logic reset_n,
  input logic fifo_full,
  input logic rsp_in_fetch
);

  a_no_push_when_full: assert property (
    @(posedge clock) disable iff (!reset_n) !(fifo_full && rsp_in_fetch)
  );

endmodule

module ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_code_o,
  output logic [XLEN-1:0] instr_pc_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [0:0]      ST_FETCH      = 1'b0;
  localparam logic [0:0]      ST_DRAIN      = 1'b1;
  localparam logic [CW-1:0]   CNT_ONE       = CW'(1'b1);
  localparam logic [CW-1:0]   CNT_ZERO      = {CW{1'b0}};
  localparam logic [AW-1:0]   PTR_ONE       = AW'(1'b1);
  localparam logic [AW-1:0]   PTR_ZERO      = {AW{1'b0}};
  localparam logic [CW:0]     DEPTH_C       = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP       = XLEN'(3'd4);
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~(XLEN'(2'b11));

  logic [0:0]      state_r, state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [CW-1:0]   fifo_count_r, fifo_count_nxt_s;
  logic [CW-1:0]   outstanding_r, outstanding_nxt_s;
  logic [AW-1:0]   wr_ptr_r, wr_ptr_nxt_s;
  logic [AW-1:0]   rd_ptr_r, rd_ptr_nxt_s;
  logic            req_r, req_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic [XLEN-1:0] code_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r   [DEPTH];

  logic            grant_s;
  logic            pop_s;
  logic            push_s;
  logic [XLEN-1:0] rsp_addr_s;

  assign grant_s = req_r & imem_gnt;
  assign pop_s   = valid_r & instr_ready_i;
  // Responses are only kept in FETCH and never in a redirect cycle.
  assign push_s  = imem_rvalid & (state_r == ST_FETCH) & ~redirect_i;
  // In FETCH all outstanding requests are consecutive words ending just
  // below fetch_pc, so the oldest one sits outstanding words back.
  assign rsp_addr_s = fetch_pc_r - (XLEN'(outstanding_r) << 2'd2);

  // Outstanding-request counter: +1 per grant, -1 per response (kept or not).
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    if (grant_s && !imem_rvalid) begin
      outstanding_nxt_s = outstanding_r + CNT_ONE;
    end else if (!grant_s && imem_rvalid) begin
      outstanding_nxt_s = outstanding_r - CNT_ONE;
    end else begin
      outstanding_nxt_s = outstanding_r;
    end
  end

  // FIFO occupancy and pointers; a redirect empties the buffer.
  always_comb begin
    fifo_count_nxt_s = fifo_count_r;
    wr_ptr_nxt_s     = wr_ptr_r;
    rd_ptr_nxt_s     = rd_ptr_r;
    if (redirect_i) begin
      fifo_count_nxt_s = CNT_ZERO;
      wr_ptr_nxt_s     = PTR_ZERO;
      rd_ptr_nxt_s     = PTR_ZERO;
    end else begin
      wr_ptr_nxt_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   fifo_count_nxt_s = fifo_count_r + CNT_ONE;
        2'b01:   fifo_count_nxt_s = fifo_count_r - CNT_ONE;
        default: fifo_count_nxt_s = fifo_count_r;
      endcase
    end
  end

  // Fetch address, state transition and the registered req/valid outputs.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    state_nxt_s    = state_r;
    if (redirect_i) begin
      fetch_pc_nxt_s = redirect_pc_i & PC_ALIGN_MASK;
      state_nxt_s    = (outstanding_nxt_s != CNT_ZERO) ? ST_DRAIN : ST_FETCH;
    end else begin
      fetch_pc_nxt_s = grant_s ? (fetch_pc_r + PC_STEP) : fetch_pc_r;
      case (state_r)
        ST_FETCH: state_nxt_s = ST_FETCH;
        ST_DRAIN: state_nxt_s = (outstanding_nxt_s == CNT_ZERO) ? ST_FETCH : ST_DRAIN;
        default:  state_nxt_s = ST_FETCH;
      endcase
    end
    req_nxt_s   = (state_nxt_s == ST_FETCH) &&
                  (({1'b0, fifo_count_nxt_s} + {1'b0, outstanding_nxt_s}) < DEPTH_C);
    valid_nxt_s = (fifo_count_nxt_s != CNT_ZERO);
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_FETCH;
      fetch_pc_r    <= RESET_PC;
      fifo_count_r  <= CNT_ZERO;
      outstanding_r <= CNT_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      req_r         <= 1'b0;
      valid_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      fetch_pc_r    <= fetch_pc_nxt_s;
      fifo_count_r  <= fifo_count_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      req_r         <= req_nxt_s;
      valid_r       <= valid_nxt_s;
    end
  end

  // FIFO storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        code_mem_r[i] <= {XLEN{1'b0}};
        pc_mem_r[i]   <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      code_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]   <= rsp_addr_s;
    end else begin
      code_mem_r[wr_ptr_r] <= code_mem_r[wr_ptr_r];
      pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
    end
  end

  assign imem_req      = req_r;
  assign imem_addr     = fetch_pc_r;
  assign instr_valid_o = valid_r;
  assign instr_code_o  = code_mem_r[rd_ptr_r];
  assign instr_pc_o    = pc_mem_r[rd_ptr_r];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_r;

  // Handshake and stall counters, free-running with natural wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_r <= 32'd0;
      perf_stall_r   <= 32'd0;
    end else begin
      perf_fetched_r <= pop_s    ? (perf_fetched_r + 32'd1) : perf_fetched_r;
      perf_stall_r   <= !valid_r ? (perf_stall_r + 32'd1)   : perf_stall_r;
    end
  end

  assign perf_fetched_o = perf_fetched_r;
  assign perf_stall_o   = perf_stall_r;
`endif

`ifndef SYNTHESIS
  ifu_prefetch_chk u_chk (
    .clock        (clock),
    .reset_n      (reset_n),
    .fifo_full    (fifo_count_r == CW'(DEPTH)),
    .rsp_in_fetch (imem_rvalid && (state_r == ST_FETCH))
  );
`endif

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter XLEN, default 32: address and instruction width in bits; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 4: prefetch FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset; bits [1:0] SHALL be zero.
REQ-004 The block has one clock and an asynchronous, active-low reset, with ports in this order:
REQ-005 clock  input  1  the only clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 imem_req  output  1  fetch request valid.
REQ-008 imem_addr  output  XLEN  fetch address; word aligned.
REQ-009 imem_gnt  input  1  the request is accepted in any cycle where imem_req and imem_gnt are both high.
REQ-010 imem_rvalid  input  1  read data valid; responses return in order, at least 1 cycle after grant.
REQ-011 imem_rdata  input  XLEN  read data.
REQ-012 redirect_i  input  1  one-cycle pulse that flushes the block and restarts fetch at redirect_pc_i.
REQ-013 redirect_pc_i  input  XLEN  redirect target; bits [1:0] are ignored and treated as zero.
REQ-014 instr_valid_o  output  1  instr_code_o and instr_pc_o are valid.
REQ-015 instr_ready_i  input  1  consumer accepts the instruction when instr_valid_o and instr_ready_i are both high.
REQ-016 instr_code_o  output  XLEN  instruction word at the FIFO head.
REQ-017 instr_pc_o  output  XLEN  address of instr_code_o.

Function
REQ-018 State machine states: FETCH and DRAIN.
REQ-019 FETCH: the block SHALL assert imem_req when fifo_count + outstanding < DEPTH; both counts are (log2(DEPTH)+1)-bit.
REQ-020 On each grant, fetch_pc advances by 4, wrapping modulo 2^XLEN; outstanding increments unless a response arrives in the same cycle.
REQ-021 Each imem_rvalid in FETCH SHALL write {imem_rdata, address} to the FIFO tail; address is the oldest outstanding request address.
REQ-022 instr_valid_o is registered: a response written in cycle t is visible at the earliest in cycle t+1; minimum grant-to-valid latency is 2 cycles.
REQ-023 FIFO full with imem_rvalid is impossible by the credit rule in REQ-019; a simulation assertion SHALL flag it.
REQ-024 Simultaneous FIFO push and pop SHALL keep fifo_count unchanged; pop from an empty FIFO is impossible because instr_valid_o is low when empty.
REQ-025 redirect_i in any state SHALL, on the next cycle: empty the FIFO, deassert instr_valid_o, latch the target into fetch_pc, and enter DRAIN if outstanding (after any same-cycle grant or response) is non-zero, otherwise FETCH.
REQ-026 DRAIN: imem_req is low; responses are discarded and decrement outstanding; the block enters FETCH in the cycle after outstanding reaches 0.
REQ-027 redirect_i during DRAIN SHALL overwrite the latched target and remain in DRAIN.
REQ-028 A handshake (valid and ready both high) in the same cycle as redirect_i counts as consumed; a response in that cycle is discarded.
REQ-029 imem_addr SHALL hold stable while imem_req is high without imem_gnt.

Reset
REQ-030 reset_n low SHALL immediately clear: imem_req=0, instr_valid_o=0, fifo_count=0, outstanding=0, state=FETCH, fetch_pc=RESET_PC.
REQ-031 instr_code_o and instr_pc_o SHALL read 0 under reset.
REQ-032 Reset asserted mid-operation SHALL discard all buffered and in-flight fetches; the first request is issued in the first cycle after reset_n rises.

Configuration
REQ-033 Macro IFU_PERF_CNT_EN defined: add outputs perf_fetched_o (32-bit, counts handshakes) and perf_stall_o (32-bit, counts cycles with instr_valid_o=0 outside reset); both wrap and reset to 0.
REQ-034 Macro IFU_PERF_CNT_EN undefined: these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-035 Reset release with RESET_PC=0x100, gnt=1, 1-cycle memory, ready=1 -> instr_pc_o sequence 0x100, 0x104, 0x108, …; first valid 2 cycles after the first grant; one instruction per cycle sustained.
REQ-036 ready=0 with DEPTH=4 -> exactly 4 grants issued, then imem_req=0; raising ready drains 0x100–0x10C in order.
REQ-037 3-cycle memory latency with 2 outstanding, then redirect to 0x2003 -> both responses discarded, DRAIN until outstanding=0, next imem_addr=0x2000, first valid instr_pc_o=0x2000.
REQ-038 Second redirect to 0x3000 during DRAIN -> next fetch at 0x3000; no instruction from 0x2000 delivered.
REQ-039 fetch_pc=0xFFFFFFFC with XLEN=32 -> next imem_addr=0x00000000.
REQ-040 reset_n pulsed low mid-stream with a full FIFO -> instr_valid_o low in the same cycle; fetch restarts at RESET_PC; with IFU_PERF_CNT_EN defined, both counters read 0.
